// File: rtl/button_pkg.sv
// button_pkg: shared debounce FSM state type and counter sizing helper.
package button_pkg;

    typedef enum logic {DB_STABLE, DB_COUNTING} debounce_state_t;

    function automatic int cnt_width(int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce_1b.sv
// button_debounce_1b: synchronizer, counter debounce and press/release pulses for one button.
module button_debounce_1b
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    debounce_state_t        state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   synced;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= DB_STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        accept    = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (synced != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = DB_COUNTING;
                    end
                end
            end
            DB_COUNTING: begin
                if (synced == level_q) begin
                    cnt_d   = '0;
                    state_d = DB_STABLE;
                end else if (cnt_q == LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DB_STABLE;
        endcase
        // Accepting flips the level; the pulse direction follows the new level.
        if (accept) begin
            level_d   = ~level_q;
            cnt_d     = '0;
            state_d   = DB_STABLE;
            press_d   = ~level_q;
            release_d = level_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchronize and debounce, producing clean levels and edge pulses.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        button_debounce_1b #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .btn_raw_i(btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench comparing the conditioner against a raw-history model.
module tb_button_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] btn_level, btn_press, btn_release;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] m_s0 = '0, m_s1 = '0, m_lvl = '0, m_prs = '0, m_rel = '0;
    int         m_run[2] = '{0, 0};
    logic [5:0] sb_q[$];
    int         press_seen[2] = '{0, 0};
    int         rel_seen[2] = '{0, 0};

    button_conditioner #(
        .N_BUTTONS      (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, advance the model, push its prediction, then pop and compare.
    task automatic step(input logic [1:0] raw, input logic r);
        logic [5:0] e;
        @(negedge clk);
        btn_raw = raw;
        rst     = r;
        @(posedge clk);
        if (r) begin
            m_s0 = '0; m_s1 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_prs[i] = 1'b0;
                m_rel[i] = 1'b0;
                if (m_s1[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_prs[i] = m_lvl[i];
                        m_rel[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s1 = m_s0;
            m_s0 = raw;
        end
        sb_q.push_back({m_lvl, m_prs, m_rel});
        #1;
        e = sb_q.pop_front();
        check("level", btn_level, e[5:4]);
        check("press", btn_press, e[3:2]);
        check("release", btn_release, e[1:0]);
        check("press_release_excl", btn_press & btn_release, 2'b00);
        for (int i = 0; i < 2; i++) begin
            press_seen[i] += int'(btn_press[i]);
            rel_seen[i]   += int'(btn_release[i]);
        end
    endtask

    task automatic clear_seen();
        press_seen = '{0, 0};
        rel_seen   = '{0, 0};
    endtask

    initial begin
        logic [1:0] bounce[12];
        bounce = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01,
                   2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};

        // Reset held 3 cycles with both buttons high
        for (int k = 0; k < 3; k++) step(2'b11, 1'b1);
        check("rst_level", btn_level, 2'b00);
        check("rst_press", btn_press, 2'b00);
        clear_seen();
        for (int k = 0; k <= 7; k++) begin
            step(2'b11, 1'b0);
            if (k == 4) check("rst_pre_level", btn_level, 2'b00);
            if (k == 5) check("rst_press_e5", btn_press, 2'b11);
            if (k == 5) check("rst_level_e5", btn_level, 2'b11);
            if (k == 6) check("rst_press_e6", btn_press, 2'b00);
        end
        check("rst_one_press", press_seen[0] + press_seen[1], 2);

        // Let both go, then a single-cycle glitch on button 1
        for (int k = 0; k < 8; k++) step(2'b00, 1'b0);
        check("released", btn_level, 2'b00);
        clear_seen();
        step(2'b10, 1'b0);
        for (int k = 0; k < 10; k++) step(2'b00, 1'b0);
        check("glitch_level", btn_level[1], 1'b0);
        check("glitch_pulses", press_seen[1] + rel_seen[1], 0);

        // Bouncing press on button 0
        clear_seen();
        for (int k = 0; k < 12; k++) begin
            step(bounce[k], 1'b0);
            if (k == 9) check("bounce_level_e9", btn_level[0], 1'b0);
            if (k == 10) check("bounce_press_e10", btn_press[0], 1'b1);
        end
        for (int k = 0; k < 4; k++) step(2'b01, 1'b0);
        check("bounce_one_press", press_seen[0], 1);
        check("bounce_level", btn_level, 2'b01);

        // Release 0 and press 1 on the same edge
        clear_seen();
        for (int k = 0; k <= 7; k++) begin
            step(2'b10, 1'b0);
            if (k == 5) check("indep_release", btn_release, 2'b01);
            if (k == 5) check("indep_press", btn_press, 2'b10);
            if (k == 5) check("indep_level", btn_level, 2'b10);
        end

        // Reset at edge 3 of a button-0 press
        clear_seen();
        for (int k = 0; k < 3; k++) step(2'b11, 1'b0);
        step(2'b11, 1'b1);
        check("midrst_level_e3", btn_level, 2'b00);
        for (int k = 4; k <= 11; k++) begin
            step(2'b11, 1'b0);
            if (k == 4) check("midrst_level_e4", btn_level, 2'b00);
            if (k == 8) check("midrst_nopulse_e8", press_seen[0] + press_seen[1], 0);
            if (k == 9) check("midrst_press_e9", btn_press, 2'b11);
        end
        check("midrst_level_end", btn_level, 2'b11);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions raw, bouncing, asynchronous push-button inputs into clean, synchronous levels and single-cycle press/release pulses. It sits between the board buttons and the magnitude comparator and LED logic, and is the producer side of their button inputs. Each button gets its own synchronizer and counter-based debounce filter, all running from one clock.

## Interface
- `N_BUTTONS`, default 2: number of independent button channels.
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchronizer; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles an input must hold its new value before it is accepted (20 ms at 50 MHz); must be ≥ 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  N_BUTTONS  raw button pins, active-high, asynchronous.
- `btn_level`  out  N_BUTTONS  debounced button state, registered.
- `btn_press`  out  N_BUTTONS  one-cycle pulse on an accepted 0→1 transition of `btn_level`.
- `btn_release`  out  N_BUTTONS  one-cycle pulse on an accepted 1→0 transition of `btn_level`.

## Operation
- Channels are fully independent. Simultaneous activity on several buttons is handled in parallel with no priority.
- Synchronizer: a `SYNC_STAGES`-deep shift register per bit. Its last stage is `sync_i`.
- Debounce FSM per channel, with states `DB_STABLE` and `DB_COUNTING`, plus counter `cnt` of width clog2(DEBOUNCE_CYCLES+1):
  - `DB_STABLE`: `cnt` = 0. If `sync_i` ≠ `btn_level[i]`, set `cnt` ← 1 and go to `DB_COUNTING`. If `DEBOUNCE_CYCLES` = 1, accept immediately instead (see below).
  - `DB_COUNTING`: if `sync_i` = `btn_level[i]` (bounce back), clear `cnt` and go to `DB_STABLE`. No output changes.
  - `DB_COUNTING`: else, if `cnt` = DEBOUNCE_CYCLES−1, accept. Otherwise `cnt` ← `cnt`+1.
  - Accept: `btn_level[i]` toggles, `cnt` clears, state returns to `DB_STABLE`. In the same cycle, pulse `btn_press[i]` (new level 1) or `btn_release[i]` (new level 0).
- Any bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count from zero. A one-cycle glitch never changes `btn_level`.
- Counter saturation cannot occur, because `cnt` never exceeds DEBOUNCE_CYCLES−1.
- Reset (`rst` = 1 on an edge), including mid-count:
  - all synchronizer stages, `cnt`, `btn_level`, `btn_press` and `btn_release` go to 0;
  - the FSM goes to `DB_STABLE`.
- No pulse is generated by reset itself or in the first cycle after it.
- A button held high through reset is accepted as a press once the full latency has elapsed after reset is released.

## Timing
- Edge 0 is the first rising edge that samples a new, thereafter stable `btn_raw[i]`.
- `sync_i` reflects that value after edge SYNC_STAGES−1.
- `btn_level[i]` and the matching pulse update on edge SYNC_STAGES+DEBOUNCE_CYCLES−1. With defaults 2 and 4 (sim), that is edge 5.
- Each pulse is high for exactly one cycle. `btn_press` and `btn_release` are never high together on the same channel.
- Minimum spacing between accepted transitions on one channel is DEBOUNCE_CYCLES cycles.
- Outputs are registered, so there is no combinational path from `btn_raw` to any output.

## Structure
- Package `button_pkg`:
  - typedef enum `debounce_state_t` {`DB_STABLE`, `DB_COUNTING`};
  - function `cnt_width(int cycles)` returning clog2(cycles+1).
- Sub-module `button_debounce_1b` holds the synchronizer, FSM, counter and pulse generation for one bit.
- The top level instantiates `button_debounce_1b` `N_BUTTONS` times in a generate loop and has no other logic.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Reset: hold `rst` for 3 cycles with `btn_raw`=2'b11. After release, all outputs are 0; `btn_level` becomes 2'b11 on edge 5 after the first post-reset edge, and `btn_press`=2'b11 for one cycle.
- Clean press: `btn_raw[0]` goes 0→1 at edge 0 and stays high. `btn_level[0]`=1 and `btn_press[0]`=1 on edge 5 only; `btn_press[0]`=0 on edge 6.
- Bounce: `btn_raw[0]` pattern 1,0,1,1,0,1,1,1,1,… starting at edge 0. No change until 4 consecutive synchronized 1s are seen; then exactly one press pulse and `btn_level[0]`=1.
- Glitch: a single-cycle 1 on `btn_raw[1]`. `btn_level[1]` stays 0 and no pulses occur.
- Release and independence: from `btn_level`=2'b01, drop `btn_raw[0]` while raising `btn_raw[1]` on the same edge. On edge 5, `btn_release[0]` and `btn_press[1]` pulse together, and `btn_level`=2'b10.
- Reset mid-count: assert `rst` at edge 3 of a press. All outputs are 0 on edge 4, and no pulse occurs until a full new 5-edge latency has elapsed after reset is released.
